count4b_down_timer: RTL and testbench

COUNT4B_DOWN_TIMER -- requirements
Module: count4b_down_timer

---
 rtl/count4b_down_timer.sv | 116 +++++++++++
 tb/tb_count4b_down_timer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/count4b_down_timer.sv
// 4-bit down-counter decremented once every TICK_DIV clocks, with IDLE/RUN/PAUSED control.
// Optional auto-reload is enabled by defining COUNT4B_AUTORELOAD_EN.
module count4b_down_timer #(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] q,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

   localparam logic [26:0] DIV_LAST = 27'(TICK_DIV - 1);

   state_t      state_q, state_d;
   logic [3:0]  q_q, q_d;
   logic [26:0] div_q, div_d;
   logic        done_q, done_d;
   logic        tick;
   logic        pause_req;
`ifdef COUNT4B_AUTORELOAD_EN
   logic [3:0]  reload_q, reload_d;
`endif

   assign tick      = (state_q == RUN) && (div_q == DIV_LAST);
   assign pause_req = pause && !start;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      div_d   = div_q;
      done_d  = 1'b0;
`ifdef COUNT4B_AUTORELOAD_EN
      reload_d = reload_q;
`endif
      case (state_q)
         IDLE, PAUSED: begin
            if (load) begin
               q_d     = load_val;
               div_d   = '0;
               state_d = IDLE;
`ifdef COUNT4B_AUTORELOAD_EN
               reload_d = load_val;
`endif
            end else if (start) begin
               if (state_q == PAUSED) begin
                  state_d = RUN;
               end else if (q_q != 4'd0) begin
                  state_d = RUN;
                  div_d   = '0;
               end
            end
         end
         RUN: begin
            // A pause freezes the divider where it is so resume finishes the period.
            if (tick)           div_d = '0;
            else if (!pause_req) div_d = div_q + 27'd1;

            if (tick) begin
               if (q_q == 4'd1) begin
                  q_d    = 4'd0;
                  done_d = 1'b1;
`ifdef COUNT4B_AUTORELOAD_EN
                  if (reload_q == 4'd0) state_d = IDLE;
`else
                  state_d = IDLE;
`endif
               end else if (q_q == 4'd0) begin
`ifdef COUNT4B_AUTORELOAD_EN
                  q_d = reload_q;
                  if (reload_q == 4'd0) state_d = IDLE;
`else
                  q_d = 4'd0;
`endif
               end else begin
                  q_d = q_q - 4'd1;
               end
            end

            if (pause_req && (state_d == RUN)) state_d = PAUSED;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         div_q   <= '0;
         done_q  <= 1'b0;
`ifdef COUNT4B_AUTORELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         div_q   <= div_d;
         done_q  <= done_d;
`ifdef COUNT4B_AUTORELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign q    = q_q;
   assign done = done_q;
   assign busy = (state_q == RUN);

endmodule

// File: tb/tb_count4b_down_timer.sv
// Directed bench for count4b_down_timer with TICK_DIV=4.
module tb_count4b_down_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] q;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_bad = 0;

   count4b_down_timer #(.TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .q(q), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic load_start(input logic [3:0] v);
      load = 1'b1; load_val = v;
      cyc();
      load = 1'b0; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      logic [3:0] prev;
      cyc();
      chk("reset_q", q, 4'd0);
      chk("reset_busy", {3'd0, busy}, 4'd0);
      chk("reset_done", {3'd0, done}, 4'd0);
      reset = 1'b0;

`ifndef COUNT4B_AUTORELOAD_EN
      // Basic countdown 3,2,1,0 with done coincident with zero.
      load = 1'b1; load_val = 4'd3;
      cyc();
      load = 1'b0;
      chk("load_q", q, 4'd3);
      chk("load_busy", {3'd0, busy}, 4'd0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("run_busy", {3'd0, busy}, 4'd1);
      for (int v = 2; v >= 0; v--) begin
         for (int k = 0; k < 3; k++) begin
            cyc();
            chk("hold_q", q, 4'(v + 1));
            chk("hold_done", {3'd0, done}, 4'd0);
         end
         cyc();
         chk("step_q", q, 4'(v));
         chk("step_done", {3'd0, done}, (v == 0) ? 4'd1 : 4'd0);
         chk("step_busy", {3'd0, busy}, (v == 0) ? 4'd0 : 4'd1);
      end
      cyc();
      chk("done_once", {3'd0, done}, 4'd0);
      chk("idle_after", {3'd0, busy}, 4'd0);
`else
      // Auto-reload: 2,1,0,2,1,0 with busy held high throughout.
      load_start(4'd2);
      prev = 4'd2;
      for (int s = 0; s < 5; s++) begin
         for (int k = 0; k < 3; k++) begin
            cyc();
            chk("ar_hold_q", q, prev);
            chk("ar_busy", {3'd0, busy}, 4'd1);
         end
         cyc();
         prev = (prev == 4'd0) ? 4'd2 : prev - 4'd1;
         chk("ar_step_q", q, prev);
         chk("ar_done", {3'd0, done}, (prev == 4'd0) ? 4'd1 : 4'd0);
         chk("ar_busy", {3'd0, busy}, 4'd1);
      end
`endif

      // Pause two cycles into a period, hold, resume; then reset mid-run.
      do_reset();
      load_start(4'd3);
      cyc();
      cyc();
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      chk("pause_busy", {3'd0, busy}, 4'd0);
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("paused_q", q, 4'd3);
      end
      chk("paused_busy", {3'd0, busy}, 4'd0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("resume_busy", {3'd0, busy}, 4'd1);
      cyc();
      chk("resume_q1", q, 4'd3);
      cyc();
      chk("resume_q2", q, 4'd2);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("abort_q", q, 4'd0);
      chk("abort_busy", {3'd0, busy}, 4'd0);
      chk("abort_done", {3'd0, done}, 4'd0);
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk("abort_no_done", {3'd0, done}, 4'd0);
      end

      // Zero load: start must not enter RUN nor pulse done.
      load_start(4'd0);
      chk("zero_busy", {3'd0, busy}, 4'd0);
      chk("zero_q", q, 4'd0);
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("zero_quiet", {3'd0, busy | done}, 4'd0);
      end

      // Load ignored in RUN; load beats start in IDLE.
      load_start(4'd5);
      cyc();
      load = 1'b1; load_val = 4'd9;
      cyc();
      load = 1'b0;
      chk("run_load_q", q, 4'd5);
      chk("run_load_busy", {3'd0, busy}, 4'd1);
      cyc();
      cyc();
      chk("run_load_dec", q, 4'd4);
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      load = 1'b1; start = 1'b1; load_val = 4'd7;
      cyc();
      load = 1'b0; start = 1'b0;
      chk("ls_q", q, 4'd7);
      chk("ls_busy", {3'd0, busy}, 4'd0);
      cyc();
      chk("ls_idle", {3'd0, busy}, 4'd0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 3; k++) cyc();
      chk("fresh_div_q", q, 4'd7);
      cyc();
      chk("fresh_div_dec", q, 4'd6);

      // Pause together with the final tick: decrement and done still happen.
      do_reset();
      load_start(4'd1);
      cyc();
      cyc();
      cyc();
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      chk("pt_q", q, 4'd0);
      chk("pt_done", {3'd0, done}, 4'd1);
      chk("pt_busy", {3'd0, busy}, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
